store_buffer: RTL and testbench
===============================

# store_buffer

Depth-parameterised FIFO between the store unit and the memory controller's cachable store port. It accepts store packets from the store unit's push channel and drains them in order to memory with a request/done handshake. It optionally forwards buffered word data to younger loads. It always reports address conflicts so the load unit can stall on partially overlapping stores.

## Interface
- DEPTH, 4, number of entries; power of two, minimum 2.
- clk_i  in  1  clock; all logic on the rising edge.
- rst_i  in  1  reset; synchronous, active-high.
- push_request_i  in  1  store unit requests a push of push_packet_i.
- push_packet_i  in  66  packet {data[65:34], address[33:2], width[1:0]}.
  - Width encoding: BYTE=0, HALF=1, WORD=2.
- full_o  out  1  buffer holds DEPTH entries.
- empty_o  out  1  buffer holds 0 entries.
- store_request_o  out  1  drain request to the memory controller.
- store_data_o  out  32  head entry data.
- store_address_o  out  32  head entry address.
- store_width_o  out  2  head entry width.
- store_done_i  in  1  memory controller completed the current request.
- fwd_address_i  in  32  load address to check.
- fwd_hit_o  out  1  forwarding hit.
- fwd_data_o  out  32  forwarded data.
- fwd_conflict_o  out  1  load must stall until the matching store drains.

## Operation
- Storage:
  - DEPTH-entry array with head and tail pointers of log2(DEPTH) bits; pointers wrap modulo DEPTH.
  - Occupancy counter of log2(DEPTH)+1 bits.
- full_o is (count==DEPTH) and empty_o is (count==0). Both are decoded from the registered count, with no same-cycle bypass.
- Push:
  - Accepted when push_request_i && !full_o. The packet is written at tail and tail increments.
  - A push while full_o is high is ignored. Nothing is written and count is unchanged.
- Drain FSM has two states, IDLE and WAIT_DONE.
  - store_request_o = (state==WAIT_DONE). Head fields drive the store_* outputs at all times.
  - IDLE: if !empty_o, go to WAIT_DONE.
  - WAIT_DONE, store_done_i high: pop the head (head++). Then:
    - Stay in WAIT_DONE if count-1+push_accepted > 0, so back-to-back requests go out with the next head presented the following cycle.
    - Otherwise go to IDLE.
  - WAIT_DONE, store_done_i low: hold. Request and head fields stay stable.
  - store_done_i is ignored in IDLE.
- Count update: count += push_accepted - pop.
  - Simultaneous push and pop leaves count unchanged.
  - When full, a pop and a push request in the same cycle pop only; the push is rejected because full_o is still high.
- Conflict check (always present):
  - Each valid entry, including the in-flight head, is compared on address[31:2] against fwd_address_i.
  - fwd_conflict_o = any matching entry that does not qualify as a forwarding hit.
  - Without forwarding, every word-address match is a conflict.
- Reset:
  - All entries are invalidated, pointers and count go to 0, FSM goes to IDLE.
  - An in-flight request is abandoned. The memory controller is reset concurrently.
- Reset values: full_o=0, empty_o=1, store_request_o=0, fwd_hit_o=0, fwd_conflict_o=0.
  - store_data_o, store_address_o, store_width_o and fwd_data_o show entry 0 content, which is don't-care.

## Timing
- Push in cycle N: empty_o falls in N+1, store_request_o rises in N+2.
- Back-to-back drain: one store retires per cycle in which store_done_i is high.
- Done in cycle M with no entries remaining (and no push in M): store_request_o falls in M+1.
- full_o rises the cycle after the push that fills the buffer. It falls the cycle after the first pop from full.
- Forward and conflict outputs are combinational from fwd_address_i and the registered entries. Zero latency.

## Configuration
- STORE_BUFFER_FORWARDING_EN defined:
  - An entry qualifies when address == fwd_address_i (all 32 bits) and width==WORD.
  - If the youngest matching entry qualifies, fwd_hit_o=1 and fwd_data_o = that entry's data, and it is not reported as a conflict.
  - If the youngest match is a BYTE/HALF store, fwd_hit_o=0 and fwd_conflict_o=1.
- Undefined: fwd_hit_o=0, fwd_data_o=0, and any word-address match raises fwd_conflict_o.

## Test plan
- Reset, then push {0xDEADBEEF, 0x00001000, WORD} in cycle 0 with store_done_i held low -> empty_o=0 at cycle 1; store_request_o=1 at cycle 2 with address 0x00001000, held stable until done.
- Push 4 packets with DEPTH=4 and no done -> full_o=1 after the 4th; a 5th push is ignored and drain order is preserved (1st address first).
- Full buffer, push_request_i and store_done_i high in the same cycle -> count goes to 3, the 5th packet is not stored, full_o=0 next cycle.
- Three entries with store_done_i held high -> three consecutive retires, addresses in push order, store_request_o low the cycle after the third done.
- Forwarding on: push WORD 0x11111111@0x2000 then WORD 0x22222222@0x2000, load 0x2000 -> fwd_hit_o=1, fwd_data_o=0x22222222; push BYTE@0x2001, load 0x2000 -> fwd_hit_o=0, fwd_conflict_o=1.
- Assert rst_i while in WAIT_DONE with 3 entries -> next cycle store_request_o=0, empty_o=1, full_o=0, fwd_conflict_o=0 for the old addresses.

Source files
------------

// File: rtl/store_buffer.sv
// store_buffer: in-order store FIFO draining to memory, with load address conflict detection and optional word forwarding (enabled by STORE_BUFFER_FORWARDING_EN)
module store_buffer #(
  parameter int DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        push_request_i,
  input  logic [65:0] push_packet_i,
  output logic        full_o,
  output logic        empty_o,
  output logic        store_request_o,
  output logic [31:0] store_data_o,
  output logic [31:0] store_address_o,
  output logic [1:0]  store_width_o,
  input  logic        store_done_i,
  input  logic [31:0] fwd_address_i,
  output logic        fwd_hit_o,
  output logic [31:0] fwd_data_o,
  output logic        fwd_conflict_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW + 1)'(DEPTH);
  localparam logic [AW:0] CNT_ONE = (AW + 1)'(1);
  typedef enum logic {IDLE, WAIT_DONE} state_e;
  state_e state_q, state_d;
  logic [AW-1:0] head_q, head_d, tail_q, tail_d, idx;
  logic [AW:0] count_q, count_d;
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [31:0] data_q [DEPTH];
  logic [31:0] addr_q [DEPTH];
  logic [1:0] width_q [DEPTH];
  logic push_acc, pop, any_match;
`ifdef STORE_BUFFER_FORWARDING_EN
  logic young_hit;
  logic [31:0] young_data;
`endif
  assign full_o = count_q == CNT_FULL;
  assign empty_o = count_q == '0;
  assign push_acc = push_request_i && !full_o;
  assign pop = state_q == WAIT_DONE && store_done_i;
  assign store_request_o = state_q == WAIT_DONE;
  assign store_data_o = data_q[head_q];
  assign store_address_o = addr_q[head_q];
  assign store_width_o = width_q[head_q];
  // next-state for pointers, occupancy, valid bits and the drain FSM
  always_comb begin
    head_d = pop ? head_q + 1'b1 : head_q;
    tail_d = push_acc ? tail_q + 1'b1 : tail_q;
    count_d = count_q + (AW + 1)'(push_acc) - (AW + 1)'(pop);
    valid_d = valid_q;
    if (pop) valid_d[head_q] = 1'b0;
    if (push_acc) valid_d[tail_q] = 1'b1;
    state_d = state_q == IDLE ? (!empty_o ? WAIT_DONE : IDLE)
            : (!store_done_i || count_q > CNT_ONE || push_acc) ? WAIT_DONE : IDLE;
  end
  // control state register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      head_q <= '0;
      tail_q <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      head_q <= head_d;
      tail_q <= tail_d;
      count_q <= count_d;
      valid_q <= valid_d;
    end
  end
  // entry payload storage; contents are meaningless unless the valid bit is set
  always_ff @(posedge clk_i) begin
    if (push_acc) begin
      data_q[tail_q] <= push_packet_i[65:34];
      addr_q[tail_q] <= push_packet_i[33:2];
      width_q[tail_q] <= push_packet_i[1:0];
    end
  end
  // scan oldest to youngest so the last match seen is the youngest one
  always_comb begin
    any_match = 1'b0;
    idx = '0;
`ifdef STORE_BUFFER_FORWARDING_EN
    young_hit = 1'b0;
    young_data = '0;
`endif
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + AW'(i);
      if (valid_q[idx] && addr_q[idx][31:2] == fwd_address_i[31:2]) begin
        any_match = 1'b1;
`ifdef STORE_BUFFER_FORWARDING_EN
        young_hit = addr_q[idx] == fwd_address_i && width_q[idx] == 2'd2;
        young_data = data_q[idx];
`endif
      end
    end
  end
`ifdef STORE_BUFFER_FORWARDING_EN
  assign fwd_hit_o = young_hit;
  assign fwd_data_o = young_hit ? young_data : '0;
  assign fwd_conflict_o = any_match && !young_hit;
`else
  assign fwd_hit_o = 1'b0;
  assign fwd_data_o = '0;
  assign fwd_conflict_o = any_match;
`endif
endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: directed stimulus with a drain scoreboard for store_buffer
module tb_store_buffer;
  logic clk_i = 0, rst_i = 1, push_request_i = 0, store_done_i = 0;
  logic [65:0] push_packet_i = '0;
  logic [31:0] fwd_address_i = '0;
  logic full_o, empty_o, store_request_o, fwd_hit_o, fwd_conflict_o;
  logic [31:0] store_data_o, store_address_o, fwd_data_o;
  logic [1:0] store_width_o;
  int passed = 0, total = 0;
  logic [65:0] exp_q [$];
  logic [65:0] mon_e;
`ifdef STORE_BUFFER_FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  store_buffer #(.DEPTH(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .push_request_i(push_request_i), .push_packet_i(push_packet_i),
    .full_o(full_o), .empty_o(empty_o), .store_request_o(store_request_o),
    .store_data_o(store_data_o), .store_address_o(store_address_o), .store_width_o(store_width_o),
    .store_done_i(store_done_i), .fwd_address_i(fwd_address_i), .fwd_hit_o(fwd_hit_o),
    .fwd_data_o(fwd_data_o), .fwd_conflict_o(fwd_conflict_o)
  );
  always #5 clk_i = ~clk_i;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s got=%h want=%h", n, act, exp);
    else passed++;
  endtask
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask
  task automatic push(input logic [31:0] d, input logic [31:0] a, input logic [1:0] w, input bit accept);
    push_request_i = 1;
    push_packet_i = {d, a, w};
    if (accept) exp_q.push_back({d, a, w});
  endtask
  // drain monitor: every retired store must match the next expected packet
  always @(negedge clk_i) begin
    if (!rst_i && store_request_o && store_done_i) begin
      if (exp_q.size() == 0) begin
        total++;
        $display("FAIL drain_extra got addr=%h want none", store_address_o);
      end else begin
        mon_e = exp_q.pop_front();
        chk("drain_addr", store_address_o, mon_e[33:2]);
        chk("drain_data", store_data_o, mon_e[65:34]);
        chk("drain_width", 32'(store_width_o), 32'(mon_e[1:0]));
      end
    end
  end
  initial begin
    tick();
    tick();
    rst_i = 0;
    chk("rst_full", 32'(full_o), 0);
    chk("rst_empty", 32'(empty_o), 1);
    chk("rst_req", 32'(store_request_o), 0);
    chk("rst_hit", 32'(fwd_hit_o), 0);
    chk("rst_conflict", 32'(fwd_conflict_o), 0);
    push(32'hDEADBEEF, 32'h00001000, 2'd2, 1);
    tick();
    push_request_i = 0;
    chk("a_empty_n1", 32'(empty_o), 0);
    chk("a_req_n1", 32'(store_request_o), 0);
    tick();
    chk("a_req_n2", 32'(store_request_o), 1);
    chk("a_addr_n2", store_address_o, 32'h00001000);
    tick();
    tick();
    chk("a_req_hold", 32'(store_request_o), 1);
    chk("a_addr_hold", store_address_o, 32'h00001000);
    chk("a_width_hold", 32'(store_width_o), 2);
    fwd_address_i = 32'h00001003;
    #1;
    chk("a_conf_unaligned", 32'(fwd_conflict_o), 1);
    chk("a_hit_unaligned", 32'(fwd_hit_o), 0);
    fwd_address_i = 32'h00001000;
    #1;
    chk("a_hit_exact", 32'(fwd_hit_o), 32'(FWD));
    chk("a_data_exact", fwd_data_o, FWD ? 32'hDEADBEEF : 32'h0);
    chk("a_conf_exact", 32'(fwd_conflict_o), 32'(!FWD));
    store_done_i = 1;
    tick();
    store_done_i = 0;
    chk("a_req_fall", 32'(store_request_o), 0);
    chk("a_empty_after", 32'(empty_o), 1);
    chk("a_conf_after", 32'(fwd_conflict_o), 0);
    for (int i = 0; i < 4; i++) begin
      push(32'hA0 + i, 32'h100 + 4 * i, 2'd2, 1);
      tick();
    end
    chk("b_full", 32'(full_o), 1);
    push(32'hA4, 32'h110, 2'd2, 0);
    tick();
    chk("b_full_hold", 32'(full_o), 1);
    chk("b_req", 32'(store_request_o), 1);
    chk("b_head_addr", store_address_o, 32'h100);
    push(32'hA5, 32'h114, 2'd2, 0);
    store_done_i = 1;
    tick();
    push_request_i = 0;
    chk("c_full_fall", 32'(full_o), 0);
    chk("c_empty", 32'(empty_o), 0);
    chk("c_next_head", store_address_o, 32'h104);
    tick();
    chk("d_req_b2b1", 32'(store_request_o), 1);
    tick();
    chk("d_req_b2b2", 32'(store_request_o), 1);
    tick();
    store_done_i = 0;
    chk("d_req_fall", 32'(store_request_o), 0);
    chk("d_empty", 32'(empty_o), 1);
    chk("d_queue_drained", 32'(exp_q.size()), 0);
    push(32'h11111111, 32'h2000, 2'd2, 1);
    tick();
    push(32'h22222222, 32'h2000, 2'd2, 1);
    tick();
    push_request_i = 0;
    fwd_address_i = 32'h2000;
    #1;
    chk("e_hit_young", 32'(fwd_hit_o), 32'(FWD));
    chk("e_data_young", fwd_data_o, FWD ? 32'h22222222 : 32'h0);
    chk("e_conf_word", 32'(fwd_conflict_o), 32'(!FWD));
    push(32'h33, 32'h2001, 2'd0, 1);
    tick();
    push_request_i = 0;
    #1;
    chk("e_hit_byte", 32'(fwd_hit_o), 0);
    chk("e_conf_byte", 32'(fwd_conflict_o), 1);
    fwd_address_i = 32'h3000;
    #1;
    chk("e_conf_miss", 32'(fwd_conflict_o), 0);
    chk("e_req_busy", 32'(store_request_o), 1);
    fwd_address_i = 32'h2000;
    rst_i = 1;
    tick();
    rst_i = 0;
    exp_q.delete();
    chk("f_req", 32'(store_request_o), 0);
    chk("f_empty", 32'(empty_o), 1);
    chk("f_full", 32'(full_o), 0);
    chk("f_conf", 32'(fwd_conflict_o), 0);
    chk("f_hit", 32'(fwd_hit_o), 0);
    push(32'hCAFEF00D, 32'h4000, 2'd1, 1);
    tick();
    push_request_i = 0;
    tick();
    chk("g_req", 32'(store_request_o), 1);
    chk("g_head_after_rst", store_address_o, 32'h4000);
    store_done_i = 1;
    tick();
    store_done_i = 0;
    chk("g_req_fall", 32'(store_request_o), 0);
    chk("g_queue_drained", 32'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
